usb_tx_encoder: RTL and testbench
=================================

USB_TX_ENCODER -- requirements
Module: usb_tx_encoder

Interface
REQ-001 Parameter STUFF_LEN, default 6: consecutive transmitted 1s after which one stuffed 0 SHALL be inserted.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 bit_strobe  input  1  one-clk pulse marking each bit-period boundary; line outputs SHALL change only on edges sampling it high.
REQ-005 tx_data  input  8  byte to transmit, LSB first; caller supplies SYNC (0x80) as first byte.
REQ-006 tx_valid  input  1  tx_data/tx_last valid.
REQ-007 tx_last  input  1  accompanying byte is final byte of packet.
REQ-008 tx_ready  output  1  holding register empty; byte accepted on edge where tx_valid && tx_ready.
REQ-009 dp  output  1  D+ line level, registered.
REQ-010 dm  output  1  D- line level, registered.
REQ-011 tx_busy  output  1  high from first byte acceptance until return to IDLE.
REQ-012 tx_error  output  1  one-clk pulse on underrun.

Function
REQ-013 Line levels SHALL be J = (dp=1,dm=0), K = (0,1), SE0 = (0,0); (1,1) SHALL never be driven.
REQ-014 Block SHALL hold one byte plus its last flag in a holding register, and one byte in a shift register with 3-bit bit index.
REQ-015 tx_ready SHALL equal NOT holding-full, registered; acceptance SHALL set holding-full on the same edge.
REQ-016 States SHALL be IDLE, SHIFT, STUFF, EOP1, EOP2, EOPJ.
REQ-017 IDLE: line SHALL be J; on bit_strobe with holding full, byte moves to shifter, ones counter clears, bit 0 is emitted on that edge, state -> SHIFT with index 1.
REQ-018 NRZI: emitted 0 SHALL toggle line (J<->K); emitted 1 SHALL hold line level.
REQ-019 Ones counter SHALL increment on each emitted 1 and clear on each emitted 0, including stuffed 0s.
REQ-020 SHIFT: each bit_strobe emits bit[index] and advances index; if counter reaches STUFF_LEN on an emitted 1, state -> STUFF and index does not advance beyond the pending bit.
REQ-021 STUFF: next bit_strobe SHALL emit a 0 (toggle), clear counter, return to SHIFT, or proceed to byte-end handling if stuffed bit followed bit 7.
REQ-022 Byte end (bit 7 emitted, any stuff bit done): if holding full, transfer to shifter on that edge, counter NOT cleared (stuffing spans bytes), next strobe emits new bit 0.
REQ-023 Byte end with last flag set: next three strobes SHALL drive SE0 (EOP1), SE0 (EOP2), J (EOPJ); then IDLE.
REQ-024 Byte end with no last flag and holding empty: underrun; tx_error SHALL pulse one clk; EOP sequence per REQ-023 SHALL follow.
REQ-025 Holding register SHALL accept bytes during EOP states; new packet starts from IDLE on the strobe after EOPJ completes.
REQ-026 With bit_strobe low, dp/dm, state, index and counter SHALL hold.
REQ-027 Transfer holding->shifter and new acceptance SHALL not occur on the same edge (tx_ready low while full).

Reset
REQ-028 rst high SHALL immediately force dp=1, dm=0, tx_ready=1, tx_busy=0, tx_error=0, state IDLE, holding empty, counter and index 0, regardless of operation in progress.
REQ-029 After rst deasserts, first accepted byte SHALL start a fresh packet from J.

Verification
REQ-030 0x80 last, from idle -> line per strobe: K J K J K J K K, SE0 SE0 J, then idle J; tx_busy drops after J.
REQ-031 0xFF last -> J J J J J J, stuffed K, K K, SE0 SE0 J (9 data-phase strobes).
REQ-032 0xFC then 0x03 last -> stuff K inserted after bit 7 of 0xFC, before bit 0 of 0x03; counter carried across boundary.
REQ-033 0x80 without tx_last, no follow-up byte -> tx_error single-clk pulse at byte end, then SE0 SE0 J.
REQ-034 rst asserted mid-byte during SHIFT -> dp=1, dm=0, tx_ready=1, tx_busy=0 same cycle asynchronously; subsequent 0x80 last reproduces REQ-030.
REQ-035 bit_strobe held low for 20 clks mid-packet -> dp/dm unchanged; sequence resumes exactly when strobes return.

Source files
------------

// File: rtl/usb_tx_encoder.sv
// USB low/full-speed transmit encoder: byte holding register, LSB-first
// shifter, NRZI line coding with bit stuffing and EOP generation.
module usb_tx_encoder #(
  parameter int STUFF_LEN = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dm,
  output logic       tx_busy,
  output logic       tx_error
);

  localparam int CW = $clog2(STUFF_LEN + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SHIFT = 3'd1;
  localparam logic [2:0] S_STUFF = 3'd2;
  localparam logic [2:0] S_EOP1  = 3'd3;
  localparam logic [2:0] S_EOP2  = 3'd4;
  localparam logic [2:0] S_EOPJ  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [7:0]    hold_q, hold_d;
  logic          hlast_q, hlast_d;
  logic          hfull_q, hfull_d;
  logic [7:0]    shift_q, shift_d;
  logic          last_q, last_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] ones_q, ones_d;
  logic          dp_q, dp_d;
  logic          dm_q, dm_d;
  logic          err_q, err_d;

  logic          do_emit;
  logic          e_bit;
  logic [CW-1:0] e_ones;
  logic [CW-1:0] ones_nx;
  logic          byte_end;

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    hlast_d  = hlast_q;
    hfull_d  = hfull_q;
    shift_d  = shift_q;
    last_d   = last_q;
    idx_d    = idx_q;
    ones_d   = ones_q;
    dp_d     = dp_q;
    dm_d     = dm_q;
    err_d    = 1'b0;
    do_emit  = 1'b0;
    e_bit    = 1'b0;
    e_ones   = ones_q;
    ones_nx  = ones_q;
    byte_end = 1'b0;

    if (tx_valid && !hfull_q) begin
      hold_d  = tx_data;
      hlast_d = tx_last;
      hfull_d = 1'b1;
    end

    if (bit_strobe) begin
      unique case (state_q)
        S_IDLE: begin
          if (hfull_q) begin
            shift_d = hold_q;
            last_d  = hlast_q;
            hfull_d = 1'b0;
            do_emit = 1'b1;
            e_bit   = hold_q[0];
            e_ones  = '0;
            idx_d   = 3'd1;
            state_d = S_SHIFT;
          end
        end
        S_SHIFT: begin
          do_emit = 1'b1;
          e_bit   = shift_q[idx_q];
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) byte_end = 1'b1;
        end
        S_STUFF: begin
          // idx wrapped to 0 means the stuffed bit followed bit 7
          do_emit = 1'b1;
          e_bit   = 1'b0;
          if (idx_q == 3'd0) byte_end = 1'b1;
          else state_d = S_SHIFT;
        end
        S_EOP1: begin
          dp_d    = 1'b0;
          dm_d    = 1'b0;
          state_d = S_EOP2;
        end
        S_EOP2: begin
          dp_d    = 1'b0;
          dm_d    = 1'b0;
          state_d = S_EOPJ;
        end
        S_EOPJ: begin
          dp_d    = 1'b1;
          dm_d    = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (do_emit) begin
        ones_nx = e_bit ? e_ones + CW'(1) : '0;
        ones_d  = ones_nx;
        dp_d    = e_bit ? dp_q : ~dp_q;
        dm_d    = e_bit ? dm_q : dp_q;
        if (e_bit && ones_nx == CW'(STUFF_LEN)) begin
          state_d  = S_STUFF;
          byte_end = 1'b0;
        end
      end

      // last flag wins over a queued byte, which then waits for IDLE
      if (byte_end) begin
        if (last_q) begin
          state_d = S_EOP1;
        end else if (hfull_q) begin
          shift_d = hold_q;
          last_d  = hlast_q;
          hfull_d = 1'b0;
          state_d = S_SHIFT;
        end else begin
          err_d   = 1'b1;
          state_d = S_EOP1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      hold_q  <= '0;
      hlast_q <= 1'b0;
      hfull_q <= 1'b0;
      shift_q <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      ones_q  <= '0;
      dp_q    <= 1'b1;
      dm_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      hlast_q <= hlast_d;
      hfull_q <= hfull_d;
      shift_q <= shift_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      dp_q    <= dp_d;
      dm_q    <= dm_d;
      err_q   <= err_d;
    end
  end

  assign tx_ready = ~hfull_q;
  assign tx_busy  = (state_q != S_IDLE) || hfull_q;
  assign tx_error = err_q;
  assign dp       = dp_q;
  assign dm       = dm_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Testbench for usb_tx_encoder: per-strobe line symbols are queued as
// expectations and popped as each bit_strobe edge is observed.
module tb_usb_tx_encoder;

  localparam logic [1:0] LJ = 2'b10;
  localparam logic [1:0] LK = 2'b01;
  localparam logic [1:0] LS = 2'b00;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_strobe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       dp;
  logic       dm;
  logic       tx_busy;
  logic       tx_error;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_q[$];
  logic [7:0] bq[$];
  bit         lq[$];
  bit         mlvl;
  int         mones;

  always #5 clk = ~clk;

  usb_tx_encoder #(.STUFF_LEN(6)) dut (
    .clk(clk),
    .rst(rst),
    .bit_strobe(bit_strobe),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_last(tx_last),
    .tx_ready(tx_ready),
    .dp(dp),
    .dm(dm),
    .tx_busy(tx_busy),
    .tx_error(tx_error)
  );

  task automatic model_reset();
    mlvl = 1'b1;
    mones = 0;
  endtask

  task automatic model_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        mones++;
        exp_q.push_back(mlvl ? LJ : LK);
        if (mones == 6) begin
          mlvl = ~mlvl;
          mones = 0;
          exp_q.push_back(mlvl ? LJ : LK);
        end
      end else begin
        mlvl = ~mlvl;
        mones = 0;
        exp_q.push_back(mlvl ? LJ : LK);
      end
    end
  endtask

  task automatic model_eop();
    exp_q.push_back(LS);
    exp_q.push_back(LS);
    exp_q.push_back(LJ);
    model_reset();
  endtask

  task automatic push_byte(input logic [7:0] d, input bit l);
    @(negedge clk);
    tx_data = d;
    tx_last = l;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL accept_ready: got %b want 0", tx_ready);
    end
    vectors++;
    if (tx_busy !== 1'b1) begin
      miscompares++;
      $display("FAIL accept_busy: got %b want 1", tx_busy);
    end
  endtask

  task automatic strobe_check();
    logic [1:0] e;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bit_strobe = 1'b1;
    @(posedge clk);
    #1;
    bit_strobe = 1'b0;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL strobe_expect: no expectation queued, line=%b", {dp, dm});
    end else begin
      e = exp_q.pop_front();
      if ({dp, dm} !== e) begin
        miscompares++;
        $display("FAIL line_symbol: got dp/dm=%b want %b", {dp, dm}, e);
      end
    end
  endtask

  task automatic run_stream(input int stall_at);
    int n = 0;
    int budget = 400;
    logic [1:0] cur;
    while (exp_q.size() > 0 && budget > 0) begin
      if (tx_ready && bq.size() > 0) push_byte(bq.pop_front(), lq.pop_front());
      if (n == stall_at) begin
        cur = {dp, dm};
        repeat (20) begin
          @(posedge clk);
          #1;
          vectors++;
          if ({dp, dm} !== cur) begin
            miscompares++;
            $display("FAIL stall_hold: got %b want %b", {dp, dm}, cur);
          end
        end
      end
      strobe_check();
      n++;
      budget--;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL stream_timeout: %0d symbols left want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if ({dp, dm} !== LJ) begin
      miscompares++;
      $display("FAIL reset_line: got %b want %b", {dp, dm}, LJ);
    end
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1", tx_ready);
    end
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: got %b want 0", tx_busy);
    end
    vectors++;
    if (tx_error !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_error: got %b want 0", tx_error);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sync();
    exp_q = {LK, LJ, LK, LJ, LK, LJ, LK, LK, LS, LS, LJ};
    bq = {8'h80};
    lq = {1'b1};
    run_stream(-1);
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sync_busy_end: got %b want 0", tx_busy);
    end
    exp_q = {LJ};
    strobe_check();
  endtask

  task automatic test_stuff_ff();
    exp_q = {LJ, LJ, LJ, LJ, LJ, LJ, LK, LK, LK, LS, LS, LJ};
    bq = {8'hFF};
    lq = {1'b1};
    run_stream(-1);
  endtask

  task automatic test_cross_byte();
    model_reset();
    model_byte(8'hFC);
    model_byte(8'h03);
    model_eop();
    bq = {8'hFC, 8'h03};
    lq = {1'b0, 1'b1};
    run_stream(-1);
  endtask

  task automatic test_underrun();
    exp_q = {LK, LJ, LK, LJ, LK, LJ, LK, LK};
    push_byte(8'h80, 1'b0);
    repeat (8) strobe_check();
    vectors++;
    if (tx_error !== 1'b1) begin
      miscompares++;
      $display("FAIL underrun_pulse: got %b want 1", tx_error);
    end
    @(posedge clk);
    #1;
    vectors++;
    if (tx_error !== 1'b0) begin
      miscompares++;
      $display("FAIL underrun_width: got %b want 0", tx_error);
    end
    exp_q = {LS, LS, LJ};
    repeat (3) strobe_check();
  endtask

  task automatic test_reset_mid();
    exp_q = {LJ, LJ, LJ};
    push_byte(8'hFF, 1'b1);
    repeat (3) strobe_check();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({dp, dm} !== LJ) begin
      miscompares++;
      $display("FAIL midrst_line: got %b want %b", {dp, dm}, LJ);
    end
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_ready: got %b want 1", tx_ready);
    end
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_busy: got %b want 0", tx_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    test_sync();
  endtask

  task automatic test_stall();
    exp_q = {LK, LJ, LK, LJ, LK, LJ, LK, LK, LS, LS, LJ};
    bq = {8'h80};
    lq = {1'b1};
    run_stream(3);
  endtask

  task automatic test_back_to_back();
    model_reset();
    model_byte(8'h80);
    model_byte(8'h3F);
    model_byte(8'hA5);
    model_eop();
    model_byte(8'h80);
    model_byte(8'hFF);
    model_eop();
    bq = {8'h80, 8'h3F, 8'hA5, 8'h80, 8'hFF};
    lq = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    run_stream(-1);
    vectors++;
    if (tx_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_busy_end: got %b want 0", tx_busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    bit_strobe = 1'b0;
    tx_valid = 1'b0;
    tx_last = 1'b0;
    tx_data = 8'h00;
    test_reset();
    test_sync();
    test_stuff_ff();
    test_cross_byte();
    test_underrun();
    test_reset_mid();
    test_stall();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
